// File: rtl/vec_dram.sv
// vec_dram: single-port word memory, RD_LAT-edge read latency, VLEN-word vector bursts; VEC_DRAM_ERR_EN enables Err.
// Backpressure: none; requests arriving while Busy is high (or with RD and WR both high) are dropped.
module vec_dram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int VLEN   = 16,
    parameter int RD_LAT = 2
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              RD,
    input  logic              WR,
    input  logic              V,
    output logic [DATA_W-1:0] DataOut,
    output logic              Valid,
    output logic              Busy,
    output logic              Err
);
    localparam int CNT_W = (VLEN > 1) ? $clog2(VLEN) : 1;

    typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              iss_rd, iss_wr;
    logic [ADDR_W-1:0] iss_addr;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] pipe_dat_q [RD_LAT];
    logic [RD_LAT-1:0] pipe_vld_q;

    // One word is issued per edge: the accepted request itself in IDLE, then one burst beat per edge.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        iss_rd   = 1'b0;
        iss_wr   = 1'b0;
        iss_addr = addr_q;
        case (state_q)
            IDLE: begin
                iss_addr = Addr;
                iss_rd   = RD & ~WR;
                iss_wr   = WR & ~RD;
                if (V && (VLEN > 1) && (RD ^ WR)) begin
                    state_d = RD ? RBURST : WBURST;
                    beat_d  = CNT_W'(1);
                    addr_d  = Addr + ADDR_W'(1);
                end
            end
            RBURST, WBURST: begin
                iss_rd = (state_q == RBURST);
                iss_wr = (state_q == WBURST);
                beat_d = beat_q + CNT_W'(1);
                addr_d = addr_q + ADDR_W'(1);
                if (beat_q == CNT_W'(VLEN - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
        end
    end

    // Array contents survive reset; a reset edge suppresses the write issued on it.
    always_ff @(posedge Clk1) begin
        if (iss_wr && !Reset) begin
            mem[iss_addr] <= DataIn;
        end
    end

    // Each stage only loads when its input is valid, so the last stage holds DataOut between reads.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            pipe_vld_q <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                pipe_dat_q[j] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= iss_rd;
            if (iss_rd) begin
                pipe_dat_q[0] <= mem[iss_addr];
            end
            for (int j = 1; j < RD_LAT; j++) begin
                pipe_vld_q[j] <= pipe_vld_q[j-1];
                if (pipe_vld_q[j-1]) begin
                    pipe_dat_q[j] <= pipe_dat_q[j-1];
                end
            end
        end
    end

    assign DataOut = pipe_dat_q[RD_LAT-1];
    assign Valid   = pipe_vld_q[RD_LAT-1];
    assign Busy    = (state_q != IDLE);

`ifdef VEC_DRAM_ERR_EN
    logic err_q;

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (RD & WR) | ((RD | WR) & (state_q != IDLE));
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_vec_dram.sv
// Randomized and directed bench for vec_dram against a word-array reference model with a per-edge expected-read schedule.
module tb_vec_dram;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int VLEN   = 16;
    localparam int RD_LAT = 2;

    logic              Clk1 = 1'b0;
    logic              Reset;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataIn;
    logic              RD, WR, V;
    logic [DATA_W-1:0] DataOut;
    logic              Valid, Busy, Err;

    vec_dram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .VLEN(VLEN), .RD_LAT(RD_LAT)) dut (
        .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .DataIn(DataIn), .RD(RD), .WR(WR), .V(V),
        .DataOut(DataOut), .Valid(Valid), .Busy(Busy), .Err(Err)
    );

    always #5 Clk1 = ~Clk1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: flat word array plus the edge at which each read word must appear.
    logic [DATA_W-1:0] m [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_dat [int];
    int                edge_no    = 1;
    int                burst_left = 0;
    logic [ADDR_W-1:0] burst_addr = '0;
    bit                burst_wr   = 1'b0;
    logic [DATA_W-1:0] last_dat   = '0;
    bit                x_busy, x_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s edge=%0d got=%h expected=%h", tag, edge_no, obs, exp);
        end
    endtask

    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (wr) m[a] = d;
        else    exp_dat[edge_no + RD_LAT - 1] = m[a];
    endtask

    task automatic cyc(input bit rst, input bit rd, input bit wr, input bit v,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit busy_b;
        bit xv;
        Reset = rst; RD = rd; WR = wr; V = v; Addr = a; DataIn = d;
        busy_b = (burst_left > 0);
        if (rst) begin
            burst_left = 0;
            for (int k = 0; k <= RD_LAT + 1; k++) exp_dat.delete(edge_no + k);
            x_busy = 1'b0;
            x_err  = 1'b0;
        end else begin
            x_err = (rd & wr) | ((rd | wr) & busy_b);
            if (busy_b) begin
                issue(burst_wr, burst_addr, d);
                burst_addr = burst_addr + 16'd1;
                burst_left--;
            end else if (rd ^ wr) begin
                issue(wr, a, d);
                if (v && VLEN > 1) begin
                    burst_left = VLEN - 1;
                    burst_addr = a + 16'd1;
                    burst_wr   = wr;
                end
            end
            x_busy = (burst_left > 0);
        end
        @(posedge Clk1);
        @(negedge Clk1);
        xv = 1'b0;
        if (rst) begin
            last_dat = '0;
        end else if (exp_dat.exists(edge_no)) begin
            xv       = 1'b1;
            last_dat = exp_dat[edge_no];
            exp_dat.delete(edge_no);
        end
        check("valid", 32'(Valid), 32'(xv));
        check("dataout", 32'(DataOut), 32'(last_dat));
        check("busy", 32'(Busy), 32'(x_busy));
`ifdef VEC_DRAM_ERR_EN
        check("err", 32'(Err), 32'(x_err));
`else
        check("err", 32'(Err), 32'd0);
`endif
        edge_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic vwr(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] seed);
        for (int i = 0; i < VLEN; i++)
            cyc(1'b0, 1'b0, (i == 0), (i == 0), base, seed + DATA_W'(i));
    endtask

    task automatic vrd(input logic [ADDR_W-1:0] base);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, base, 16'h0000);
        idle(VLEN - 1);
    endtask

    initial begin
        Reset = 1'b1; RD = 1'b0; WR = 1'b0; V = 1'b0; Addr = '0; DataIn = '0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Known contents for every address the random phase may touch.
        for (int b = 0; b < 6; b++) vwr(16'(b * 16), 16'($urandom));
        idle(2);

        // Scalar write then read back.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        idle(RD_LAT + 2);

        // Vector write/read at 0x0100.
        vwr(16'h0100, 16'h1000);
        vrd(16'h0100);
        idle(RD_LAT + 1);

        // Address wrap at the top of the array.
        vwr(16'hFFF8, 16'($urandom));
        vrd(16'hFFF8);
        idle(RD_LAT + 1);

        // RD and WR together are a no-op.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h5A5A);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        idle(RD_LAT + 1);

        // Reset at beat 5 of a vector write aborts the rest of the burst.
        vwr(16'h0200, 16'hA000);
        idle(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'hB000);
        for (int i = 1; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hB000 + 16'(i));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hB005);
        idle(1);
        vrd(16'h0200);
        idle(RD_LAT + 1);

        // Back-to-back scalar reads.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0011, 16'hC0DE);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000);
        idle(RD_LAT + 2);

        // Random traffic, including requests during bursts, RD&WR collisions and stray resets.
        for (int n = 0; n < 3000; n++) begin
            int  r;
            bit  rd, wr, rst;
            r   = $urandom_range(0, 9);
            rd  = (r <= 2) || (r == 6);
            wr  = (r >= 3 && r <= 6);
            rst = ($urandom_range(0, 99) == 0);
            cyc(rst, rd, wr, ($urandom_range(0, 2) == 0),
                16'($urandom_range(0, 63)), 16'($urandom));
        end
        idle(VLEN + RD_LAT + 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
